// File: rtl/mem_write_checker_if.sv
// Bundle of the checker's control, monitored write port and status signals.
// The checker uses the slave view; the bench or debug wrapper drives the master view.
interface mem_write_checker_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_byte;
    logic              ld_ready;
    logic              start;
    logic              clear;
    logic              MemWrite;
    logic [ADDR_W-1:0] DataAdr;
    logic [DATA_W-1:0] WriteData;
    logic              ByteMem;
    logic              busy;
    logic              done;
    logic              pass;
    logic              fail;
    logic [1:0]        fail_code;
    logic [CW-1:0]     match_count;
    logic [CW-1:0]     entry_count;
    logic [CW-1:0]     fail_idx;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_data;
    logic [TW-1:0]     cycle_count;

    modport slave (
        input  ld_valid, ld_addr, ld_data, ld_byte, start, clear,
        input  MemWrite, DataAdr, WriteData, ByteMem,
        output ld_ready, busy, done, pass, fail, fail_code,
        output match_count, entry_count, fail_idx, fail_addr, fail_data, cycle_count
    );

    modport master (
        output ld_valid, ld_addr, ld_data, ld_byte, start, clear,
        output MemWrite, DataAdr, WriteData, ByteMem,
        input  ld_ready, busy, done, pass, fail, fail_code,
        input  match_count, entry_count, fail_idx, fail_addr, fail_data, cycle_count
    );
endinterface

// File: rtl/mem_write_checker.sv
// Checks data-memory writes against a loaded table of expected writes, with ordering and timeout.
// Verdict registered at the edge of the deciding write; loads accepted only in IDLE while not full.
module mem_write_checker #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024,
    parameter int STRICT  = 1
) (
    input logic clk,
    input logic reset,
    mem_write_checker_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t state, state_nxt;

    logic [DEPTH-1:0][ADDR_W-1:0] exp_addr;
    logic [DEPTH-1:0][DATA_W-1:0] exp_data;
    logic [DEPTH-1:0]             exp_byte;

    logic [CW-1:0]     entry_count, match_count, fail_idx;
    logic [TW-1:0]     cycle_count;
    logic [1:0]        fail_code;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_data;

    logic [IW-1:0] cur_idx, ld_idx;
    logic          full, data_eq, hit, last_cyc;
    logic          do_load, do_start, do_match, do_tick, fail_mis, fail_to;

    assign cur_idx  = match_count[IW-1:0];
    assign ld_idx   = entry_count[IW-1:0];
    assign full     = (entry_count == CW'(DEPTH));
    assign last_cyc = (cycle_count == TW'(TIMEOUT - 1));

    // Byte entries only care about the low lane; upper data bits are don't-care.
    assign data_eq = exp_byte[cur_idx] ? (bus.WriteData[7:0] == exp_data[cur_idx][7:0])
                                       : (bus.WriteData == exp_data[cur_idx]);
    assign hit = bus.MemWrite && (bus.DataAdr == exp_addr[cur_idx]) &&
                 (bus.ByteMem == exp_byte[cur_idx]) && data_eq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_start  = 1'b0;
        do_match  = 1'b0;
        do_tick   = 1'b0;
        fail_mis  = 1'b0;
        fail_to   = 1'b0;
        if (bus.clear) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        do_start  = 1'b1;
                        state_nxt = (entry_count == '0) ? S_PASS : S_RUN;
                    end else if (bus.ld_valid && !full) begin
                        do_load = 1'b1;
                    end
                end
                S_RUN: begin
                    do_match = hit;
                    // Completion on the final cycle takes precedence over timeout.
                    if (hit && (match_count + CW'(1) == entry_count)) begin
                        state_nxt = S_PASS;
                    end else if (bus.MemWrite && !hit && (STRICT != 0)) begin
                        state_nxt = S_FAIL;
                        fail_mis  = 1'b1;
                    end else if (last_cyc) begin
                        state_nxt = S_FAIL;
                        fail_to   = 1'b1;
                    end else begin
                        do_tick = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_addr    <= '0;
            exp_data    <= '0;
            exp_byte    <= '0;
            entry_count <= '0;
            match_count <= '0;
            cycle_count <= '0;
            fail_idx    <= '0;
            fail_code   <= 2'b00;
            fail_addr   <= '0;
            fail_data   <= '0;
        end else if (bus.clear) begin
            exp_addr    <= '0;
            exp_data    <= '0;
            exp_byte    <= '0;
            entry_count <= '0;
            match_count <= '0;
            cycle_count <= '0;
            fail_idx    <= '0;
            fail_code   <= 2'b00;
            fail_addr   <= '0;
            fail_data   <= '0;
        end else begin
            if (do_load) begin
                exp_addr[ld_idx] <= bus.ld_addr;
                exp_data[ld_idx] <= bus.ld_data;
                exp_byte[ld_idx] <= bus.ld_byte;
                entry_count      <= entry_count + CW'(1);
            end
            if (do_start) begin
                match_count <= '0;
                cycle_count <= '0;
            end
            if (do_match) match_count <= match_count + CW'(1);
            if (do_tick)  cycle_count <= cycle_count + TW'(1);
            if (fail_mis) begin
                fail_code <= 2'b01;
                fail_idx  <= match_count;
                fail_addr <= bus.DataAdr;
                fail_data <= bus.WriteData;
            end
            // A match in the timeout cycle still advances the outstanding index.
            if (fail_to) begin
                fail_code <= 2'b10;
                fail_idx  <= do_match ? match_count + CW'(1) : match_count;
            end
        end
    end

    assign bus.ld_ready    = (state == S_IDLE) && !full;
    assign bus.busy        = (state == S_RUN);
    assign bus.done        = (state == S_PASS) || (state == S_FAIL);
    assign bus.pass        = (state == S_PASS);
    assign bus.fail        = (state == S_FAIL);
    assign bus.fail_code   = fail_code;
    assign bus.match_count = match_count;
    assign bus.entry_count = entry_count;
    assign bus.fail_idx    = fail_idx;
    assign bus.fail_addr   = fail_addr;
    assign bus.fail_data   = fail_data;
    assign bus.cycle_count = cycle_count;
endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable self-check monitor on the processor data-memory write port (MemWrite, DataAdr, WriteData, ByteMem).
- Generalises the single hard-coded "write 5 to address 200" check into a DEPTH-entry table of expected writes. Adds word/byte modes, strict or lenient ordering, a cycle timeout and captured failure information.
- Sits beside top in simulation benches and on-board debug builds. Drives pass/fail status instead of $display.

Parameters:
- ADDR_W, 32, width of monitored address bus.
- DATA_W, 32, width of monitored write data (must be >= 8).
- DEPTH, 8, number of expected-write entries (>= 1).
- TIMEOUT, 1024, maximum RUN cycles before a timeout failure (>= 2).
- STRICT, 1, 1 = any non-matching write fails; 0 = non-matching writes are ignored.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ld_valid  in  1  load one expected entry (IDLE only).
- ld_addr  in  ADDR_W  expected address.
- ld_data  in  DATA_W  expected data.
- ld_byte  in  1  expected write is a byte write.
- ld_ready  out  1  table accepts loads (IDLE and not full).
- start  in  1  single-cycle pulse; begin checking.
- clear  in  1  synchronous return to IDLE, table emptied.
- MemWrite  in  1  monitored write strobe.
- DataAdr  in  ADDR_W  monitored address.
- WriteData  in  DATA_W  monitored data.
- ByteMem  in  1  monitored byte-write flag.
- busy  out  1  state == RUN.
- done  out  1  state is PASS or FAIL.
- pass  out  1  state == PASS.
- fail  out  1  state == FAIL.
- fail_code  out  2  00 none, 01 mismatch, 10 timeout.
- match_count  out  $clog2(DEPTH+1)  entries matched so far.
- entry_count  out  $clog2(DEPTH+1)  entries loaded.
- fail_idx  out  $clog2(DEPTH+1)  index expected at failure.
- fail_addr  out  ADDR_W  DataAdr captured at mismatch.
- fail_data  out  DATA_W  WriteData captured at mismatch.
- cycle_count  out  $clog2(TIMEOUT+1)  RUN cycles elapsed.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE; table emptied.
  - All outputs 0 except ld_ready = 1.
  - Applies at any time, including mid-RUN.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> PASS when the last entry matches.
  - RUN -> FAIL on mismatch or timeout.
  - PASS/FAIL are sticky until clear or reset.
  - clear returns from any state to IDLE and zeroes all counters, captures and the table. clear has priority over every other input.
- Load:
  - In IDLE with ld_valid && ld_ready, the entry is written at index entry_count and entry_count increments.
  - Loads when full or outside IDLE are dropped.
  - ld_valid and start in the same cycle: start wins and the load is dropped.
- Start:
  - start in IDLE zeroes match_count and cycle_count and enters RUN at that edge.
  - A write in the same cycle as start is not checked.
  - start while entry_count == 0: go directly to PASS.
  - start outside IDLE is ignored.
- Match rule, for entry i = match_count:
  - Requires MemWrite, DataAdr == exp_addr[i], and ByteMem == exp_byte[i].
  - Word entry: data compare on all DATA_W bits.
  - Byte entry: data compare on bits [7:0] only.
  - The comparison is registered at the edge; outputs are updated at that edge.
- On match: match_count increments. If the new count equals entry_count, go to PASS at the same edge.
- On a non-matching MemWrite:
  - STRICT = 1: go to FAIL with fail_code 01. fail_idx = match_count; fail_addr/fail_data = DataAdr/WriteData of that cycle.
  - STRICT = 0: no effect.
- Cycles with MemWrite low are never checked.
- Timeout:
  - cycle_count increments every RUN cycle.
  - If cycle_count == TIMEOUT-1 and the run does not complete in that cycle: go to FAIL with fail_code 10 and fail_idx = match_count. fail_addr/fail_data stay 0.
  - Completion in the final cycle wins over timeout.
- After done: MemWrite is ignored and counters freeze.

Test Plan:
- Load 1 word entry (200, 5); start; MemWrite at 200 with data 5 on RUN cycle 3 -> pass=1 after that edge, match_count=1, cycle_count=3, fail_code=00.
- STRICT=1, entries (0x60, 7) then (0x64, 9); write 0x60/7 then 0x64/8 -> fail=1, fail_code=01, fail_idx=1, fail_addr=0x64, fail_data=8.
- STRICT=0, same entries; writes 0x80/1, 0x60/7, 0x90/2, 0x64/9 -> pass=1, match_count=2.
- Byte entry (0x10, 0xAB, byte); write 0x10 with data 0x123456AB and ByteMem=1 -> pass. Same write with ByteMem=0 and STRICT=1 -> fail_code=01.
- TIMEOUT=16, one entry, no writes -> fail=1, fail_code=10 after exactly 16 RUN cycles, cycle_count=15. Matching write on cycle 15 instead -> pass.
- Load DEPTH+1 entries -> entry_count=DEPTH and ld_ready=0. Assert reset low mid-RUN -> all outputs 0 and ld_ready=1 immediately, without waiting for a clock. Then start with an empty table -> pass next edge.
